// File: rtl/jpeg_pkg.sv
// Shared types and constants for the JPEG entropy front end: coefficient type,
// block geometry, special run codes and the RLE sequencer state encoding.
package jpeg_pkg;

  typedef logic signed [10:0] coef_t;

  localparam int NUM_COEF = 64;
  localparam int RUN_MAX  = 15;

  localparam logic [5:0] LAST_IDX = 6'(NUM_COEF - 1);
  localparam logic [3:0] ZRL_RUN  = 4'hF;
  localparam logic [3:0] EOB_RUN  = 4'h0;

  localparam coef_t COEF_MIN   = 11'sh400;
  localparam coef_t AC_SAT_NEG = 11'sh401;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_DC,
    ST_EMIT_DC,
    ST_SCAN,
    ST_EMIT_ZRL,
    ST_EMIT_AC,
    ST_EMIT_EOB,
    ST_FIN,
    ST_FLUSH_GAP,
    ST_FLUSH_WAIT
  } seq_state_t;

  // -1024 has no 10-bit magnitude, so AC values are clamped to +/-1023.
  function automatic coef_t sat_ac(input coef_t v);
    return (v == COEF_MIN) ? AC_SAT_NEG : v;
  endfunction

endpackage

// File: rtl/ones_encoder.sv
// Magnitude category and ones-complement value bits of a signed coefficient.
// The input must already lie in [-(2^(WIDTH-1)-1), 2^(WIDTH-1)-1].
module ones_encoder #(
  parameter int WIDTH = 11
) (
  input  logic [WIDTH-1:0] value_i,
  output logic [3:0]       size_o,
  output logic [WIDTH-2:0] bits_o
);

  logic             neg;
  logic [WIDTH-2:0] mag;
  logic [WIDTH-2:0] mask;

  // Negative values emit the low size bits of (v-1), which equal ~|v|.
  always_comb begin
    neg    = value_i[WIDTH-1];
    mag    = neg ? (~value_i[WIDTH-2:0] + (WIDTH-1)'(1)) : value_i[WIDTH-2:0];
    size_o = '0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (mag[i]) size_o = 4'(i + 1);
    end
    mask = '0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      mask[i] = (4'(i) < size_o);
    end
    bits_o = (neg ? ~mag : mag) & mask;
  end

endmodule

// File: rtl/rle_sequencer.sv
// Per-block run-length sequencer: scans 64 zig-zag coefficients and feeds
// DC, AC, ZRL and EOB symbols (plus the end-of-scan flush) to huffman_coder.
module rle_sequencer
  import jpeg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        last_block,
  output logic        busy,
  output logic        done,
  output logic [5:0]  coef_addr,
  input  logic [10:0] coef_rdata,
  output logic        hc_ena,
  input  logic        hc_rdy,
  output logic        hc_dc,
  output logic [10:0] hc_in_dc,
  output logic [3:0]  hc_run,
  output logic [3:0]  hc_size,
  output logic [9:0]  hc_in,
  output logic        hc_flush
);

  seq_state_t state_q, state_d;
  logic [5:0] addr_q, addr_d;
  logic [5:0] idx_q, idx_d;
  logic [5:0] run_q, run_d;
  coef_t      dc_q, dc_d;
  coef_t      ac_q, ac_d;
  logic       last_q, last_d;
  logic       holdoff_q;

  logic       hc_dc_q;
  coef_t      hc_in_dc_q;
  logic [3:0] hc_run_q, hc_size_q;
  logic [9:0] hc_in_q;

  logic       strobe, flush, done_c, can_send;
  logic       sym_dc;
  logic [3:0] sym_run, sym_size;
  logic [9:0] sym_in;
  logic [3:0] enc_size;
  logic [9:0] enc_bits;

  ones_encoder #(.WIDTH(11)) u_enc (
    .value_i (ac_q),
    .size_o  (enc_size),
    .bits_o  (enc_bits)
  );

  // The coder's rdy drops one cycle late, so the cycle after any strobe is blind.
  assign can_send = hc_rdy && !holdoff_q;

  // In SCAN addr_q runs one ahead of idx_q; emit states hold the address so
  // returning to SCAN re-reads it without a bubble.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    idx_d    = idx_q;
    run_d    = run_q;
    dc_d     = dc_q;
    ac_d     = ac_q;
    last_d   = last_q;
    strobe   = 1'b0;
    flush    = 1'b0;
    done_c   = 1'b0;
    sym_dc   = 1'b0;
    sym_run  = EOB_RUN;
    sym_size = 4'd0;
    sym_in   = 10'd0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          last_d  = last_block;
          addr_d  = 6'd0;
          idx_d   = 6'd0;
          run_d   = 6'd0;
          state_d = ST_RD_DC;
        end
      end
      ST_RD_DC: begin
        dc_d    = coef_t'(coef_rdata);
        addr_d  = 6'd1;
        state_d = ST_EMIT_DC;
      end
      ST_EMIT_DC: begin
        sym_dc = 1'b1;
        if (can_send) begin
          strobe  = 1'b1;
          idx_d   = 6'd1;
          addr_d  = 6'd2;
          run_d   = 6'd0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (coef_rdata == 11'd0) begin
          run_d = run_q + 6'd1;
          if (idx_q == LAST_IDX) begin
            state_d = ST_EMIT_EOB;
          end else begin
            idx_d  = idx_q + 6'd1;
            addr_d = addr_q + 6'd1;
          end
        end else begin
          ac_d    = sat_ac(coef_t'(coef_rdata));
          state_d = (run_q > 6'(RUN_MAX)) ? ST_EMIT_ZRL : ST_EMIT_AC;
        end
      end
      ST_EMIT_ZRL: begin
        sym_run = ZRL_RUN;
        if (can_send) begin
          strobe = 1'b1;
          run_d  = run_q - 6'd16;
          if (run_d <= 6'(RUN_MAX)) state_d = ST_EMIT_AC;
        end
      end
      ST_EMIT_AC: begin
        sym_run  = run_q[3:0];
        sym_size = enc_size;
        sym_in   = enc_bits;
        if (can_send) begin
          strobe = 1'b1;
          run_d  = 6'd0;
          if (idx_q == LAST_IDX) begin
            state_d = ST_FIN;
          end else begin
            idx_d   = idx_q + 6'd1;
            addr_d  = addr_q + 6'd1;
            state_d = ST_SCAN;
          end
        end
      end
      ST_EMIT_EOB: begin
        sym_run = EOB_RUN;
        if (can_send) begin
          strobe  = 1'b1;
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        if (!last_q) begin
          done_c  = 1'b1;
          addr_d  = 6'd0;
          state_d = ST_IDLE;
        end else if (can_send) begin
          flush   = 1'b1;
          state_d = ST_FLUSH_GAP;
        end
      end
      ST_FLUSH_GAP: begin
        state_d = ST_FLUSH_WAIT;
      end
      ST_FLUSH_WAIT: begin
        if (hc_rdy) begin
          done_c  = 1'b1;
          addr_d  = 6'd0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      idx_q     <= '0;
      run_q     <= '0;
      dc_q      <= '0;
      ac_q      <= '0;
      last_q    <= 1'b0;
      holdoff_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      idx_q     <= idx_d;
      run_q     <= run_d;
      dc_q      <= dc_d;
      ac_q      <= ac_d;
      last_q    <= last_d;
      holdoff_q <= strobe | flush;
    end
  end

  // Symbol fields are live during the strobe and held afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hc_dc_q    <= 1'b0;
      hc_in_dc_q <= '0;
      hc_run_q   <= '0;
      hc_size_q  <= '0;
      hc_in_q    <= '0;
    end else if (strobe) begin
      hc_dc_q    <= sym_dc;
      hc_in_dc_q <= dc_q;
      hc_run_q   <= sym_run;
      hc_size_q  <= sym_size;
      hc_in_q    <= sym_in;
    end
  end

  assign hc_ena    = strobe;
  assign hc_flush  = flush;
  assign done      = done_c;
  assign busy      = (state_q != ST_IDLE) && !done_c;
  assign coef_addr = addr_q;
  assign hc_dc     = strobe ? sym_dc   : hc_dc_q;
  assign hc_in_dc  = strobe ? dc_q     : hc_in_dc_q;
  assign hc_run    = strobe ? sym_run  : hc_run_q;
  assign hc_size   = strobe ? sym_size : hc_size_q;
  assign hc_in     = strobe ? sym_in   : hc_in_q;

endmodule

// File: tb/tb_rle_sequencer.sv
// Scoreboard bench for rle_sequencer: directed blocks push expected symbols,
// a negedge monitor pops and compares every strobe and flush the DUT issues.
module tb_rle_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        last_block = 1'b0;
  logic        busy, done;
  logic [5:0]  coef_addr;
  logic [10:0] coef_rdata;
  logic        hc_ena, hc_rdy, hc_dc, hc_flush;
  logic [10:0] hc_in_dc;
  logic [3:0]  hc_run, hc_size;
  logic [9:0]  hc_in;

  logic [10:0] mem [64];
  logic [31:0] expQ [$];
  int          checks = 0;
  int          errors = 0;
  int          doneCount = 0;
  int          stallCnt = 0;
  logic        rdyStall = 1'b0;
  logic        flushSeen = 1'b0;

  rle_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .last_block (last_block),
    .busy       (busy),
    .done       (done),
    .coef_addr  (coef_addr),
    .coef_rdata (coef_rdata),
    .hc_ena     (hc_ena),
    .hc_rdy     (hc_rdy),
    .hc_dc      (hc_dc),
    .hc_in_dc   (hc_in_dc),
    .hc_run     (hc_run),
    .hc_size    (hc_size),
    .hc_in      (hc_in),
    .hc_flush   (hc_flush)
  );

  always #5 clk = ~clk;

  always @(posedge clk) coef_rdata <= mem[coef_addr];

  // Coder responder: optionally drops rdy for 5 cycles after each strobe/flush.
  always @(posedge clk) begin
    if (rdyStall && (hc_ena || hc_flush)) stallCnt <= 5;
    else if (stallCnt > 0) stallCnt <= stallCnt - 1;
  end
  assign hc_rdy = (stallCnt == 0);

  function automatic logic [31:0] symVec(input logic isFlush, input logic dc,
                                         input logic [10:0] inDc, input logic [3:0] run,
                                         input logic [3:0] size, input logic [9:0] inBits);
    return {1'b0, isFlush, dc, (dc ? inDc : 11'd0), run, size, inBits};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic expectSym(input logic dc, input logic [10:0] inDc, input logic [3:0] run,
                           input logic [3:0] size, input logic [9:0] inBits);
    expQ.push_back(symVec(1'b0, dc, inDc, run, size, inBits));
  endtask

  task automatic expectFlush();
    expQ.push_back(symVec(1'b1, 1'b0, 11'd0, 4'd0, 4'd0, 10'd0));
  endtask

  task automatic clearMem();
    for (int i = 0; i < 64; i++) mem[i] = 11'd0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (hc_ena || hc_flush) begin
        logic [31:0] act;
        checkOutput("rdyHonoured", {31'd0, hc_rdy}, 32'd1);
        act = hc_flush ? symVec(1'b1, 1'b0, 11'd0, 4'd0, 4'd0, 10'd0)
                       : symVec(1'b0, hc_dc, hc_in_dc, hc_run, hc_size, hc_in);
        if (hc_flush) flushSeen = 1'b1;
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedSym actual=%h required=none at %0t", act, $time);
        end else begin
          checkOutput("sym", act, expQ.pop_front());
        end
      end
      if (done) begin
        doneCount++;
        if (flushSeen) begin
          checkOutput("doneAfterRdy", {31'd0, hc_rdy}, 32'd1);
          flushSeen = 1'b0;
        end
      end
    end
  end

  task automatic applyStimulus(input logic lastBlk, input logic stall, input logic pokeStart,
                               input string name);
    int cyc;
    int doneBefore;
    rdyStall = stall;
    doneBefore = doneCount;
    @(negedge clk);
    start = 1'b1;
    last_block = lastBlk;
    @(negedge clk);
    start = 1'b0;
    last_block = 1'b0;
    checkOutput({name, "_busy"}, {31'd0, busy}, 32'd1);
    if (pokeStart) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    cyc = 0;
    while (doneCount == doneBefore && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    checkOutput({name, "_donePulse"}, 32'(doneCount - doneBefore), 32'd1);
    checkOutput({name, "_idleBusy"}, {31'd0, busy}, 32'd0);
    checkOutput({name, "_queueEmpty"}, 32'(expQ.size()), 32'd0);
    expQ.delete();
  endtask

  initial begin
    clearMem();
    repeat (2) @(negedge clk);
    checkOutput("resetOutputs",
                {busy, done, hc_ena, hc_flush, hc_dc, hc_run, hc_size, coef_addr, 12'd0},
                32'd0);
    checkOutput("resetFields", {hc_in_dc, hc_in, 11'd0}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: all-zero block -> DC(0), EOB
    clearMem();
    expectSym(1'b1, 11'd0, 4'd0, 4'd0, 10'd0);
    expectSym(1'b0, 11'd0, 4'd0, 4'd0, 10'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, "allZero");

    // 2: DC=-37, +5, -1
    clearMem();
    mem[0] = 11'h7DB;
    mem[1] = 11'd5;
    mem[2] = 11'h7FF;
    expectSym(1'b1, 11'h7DB, 4'd0, 4'd0, 10'd0);
    expectSym(1'b0, 11'd0, 4'd0, 4'd3, 10'b101);
    expectSym(1'b0, 11'd0, 4'd0, 4'd1, 10'd0);
    expectSym(1'b0, 11'd0, 4'd0, 4'd0, 10'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, "dcAc");

    // 3: run of 33 -> two ZRLs then AC(run1)
    clearMem();
    mem[0] = 11'd12;
    mem[34] = 11'd1;
    expectSym(1'b1, 11'd12, 4'd0, 4'd0, 10'd0);
    expectSym(1'b0, 11'd0, 4'hF, 4'd0, 10'd0);
    expectSym(1'b0, 11'd0, 4'hF, 4'd0, 10'd0);
    expectSym(1'b0, 11'd0, 4'd1, 4'd1, 10'd1);
    expectSym(1'b0, 11'd0, 4'd0, 4'd0, 10'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, "zrl");

    // 4: -1024 at index 63 -> three ZRLs, saturated AC, no EOB
    clearMem();
    mem[63] = 11'h400;
    expectSym(1'b1, 11'd0, 4'd0, 4'd0, 10'd0);
    expectSym(1'b0, 11'd0, 4'hF, 4'd0, 10'd0);
    expectSym(1'b0, 11'd0, 4'hF, 4'd0, 10'd0);
    expectSym(1'b0, 11'd0, 4'hF, 4'd0, 10'd0);
    expectSym(1'b0, 11'd0, 4'd14, 4'd10, 10'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, "lastCoef");

    // 5: last block with a stalling coder -> symbols, then one flush
    clearMem();
    mem[0] = 11'h7DB;
    mem[1] = 11'd5;
    mem[2] = 11'h7FF;
    expectSym(1'b1, 11'h7DB, 4'd0, 4'd0, 10'd0);
    expectSym(1'b0, 11'd0, 4'd0, 4'd3, 10'b101);
    expectSym(1'b0, 11'd0, 4'd0, 4'd1, 10'd0);
    expectSym(1'b0, 11'd0, 4'd0, 4'd0, 10'd0);
    expectFlush();
    applyStimulus(1'b1, 1'b1, 1'b0, "stallFlush");

    // 6: reset in the middle of SCAN, then a clean last block
    begin
      int doneBefore;
      clearMem();
      mem[34] = 11'd1;
      rdyStall = 1'b0;
      doneBefore = doneCount;
      expectSym(1'b1, 11'd0, 4'd0, 4'd0, 10'd0);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("midResetOutputs",
                  {busy, done, hc_ena, hc_flush, hc_dc, hc_run, hc_size, coef_addr, 12'd0},
                  32'd0);
      checkOutput("midResetFields", {hc_in_dc, hc_in, 11'd0}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      expQ.delete();
      flushSeen = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("midResetNoDone", 32'(doneCount - doneBefore), 32'd0);
    end
    clearMem();
    mem[0] = 11'd3;
    mem[5] = 11'h7FB;
    expectSym(1'b1, 11'd3, 4'd0, 4'd0, 10'd0);
    expectSym(1'b0, 11'd0, 4'd4, 4'd3, 10'b010);
    expectSym(1'b0, 11'd0, 4'd0, 4'd0, 10'd0);
    expectFlush();
    applyStimulus(1'b1, 1'b0, 1'b0, "afterReset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
